// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings and
// handshake/constant values used by the execute-stage hi/lo path.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam int          DoubleRegBus = 64;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per clock, producing
// {remainder, quotient} for DIV/DIVU with annulment support.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2*WIDTH:0]   work, work_n;
    logic [WIDTH-1:0]   divisor, divisor_n;
    logic               neg1, neg1_n;
    logic               neg2, neg2_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   mag1, mag2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            work     <= work_n;
            divisor  <= divisor_n;
            neg1     <= neg1_n;
            neg2     <= neg2_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        neg1_n    = neg1;
        neg2_n    = neg2;
        result_n  = '0;
        ready_n   = DivResultNotReady;

        // Sign flags are captured at start so operand inputs may change freely afterwards.
        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
        diff = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = DivByZero;
                    end else begin
                        state_n   = DivOn;
                        cnt_n     = '0;
                        neg1_n    = signed_div_i & opdata1_i[WIDTH-1];
                        neg2_n    = signed_div_i & opdata2_i[WIDTH-1];
                        work_n    = {{WIDTH{1'b0}}, mag1, 1'b0};
                        divisor_n = mag2;
                    end
                end
            end

            DivByZero: begin
                work_n  = '0;
                state_n = DivEnd;
            end

            DivOn: begin
                if (annul_i) begin
                    state_n = DivFree;
                    cnt_n   = '0;
                end else if (cnt != CNT_W'(WIDTH)) begin
                    // Remainder window sits one bit above the quotient; a negative diff restores.
                    if (diff[WIDTH]) begin
                        work_n = {work[2*WIDTH-1:0], 1'b0};
                    end else begin
                        work_n = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
                    end
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    if (neg1 ^ neg2) begin
                        work_n[WIDTH-1:0] = ~work[WIDTH-1:0] + 1'b1;
                    end
                    if (neg1) begin
                        work_n[2*WIDTH:WIDTH+1] = ~work[2*WIDTH:WIDTH+1] + 1'b1;
                    end
                    state_n = DivEnd;
                    cnt_n   = '0;
                end
            end

            DivEnd: begin
                if (start_i == DivStart) begin
                    result_n = {work[2*WIDTH:WIDTH+1], work[WIDTH-1:0]};
                    ready_n  = DivResultReady;
                end else begin
                    state_n = DivFree;
                end
            end

            default: state_n = DivFree;
        endcase
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU.
- Execute stage raises start_i, holds the pipeline via its stall request while ready_o is low, then writes {remainder, quotient} into HI/LO through the EX/MEM buffer's hilo path.
- Radix-2 restoring algorithm, one quotient bit per clock. Supports signed and unsigned operation and annulment.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  division request, held high by EX until result consumed
- annul_i  in  1  cancel in-flight division (flush/exception)
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result valid

Behaviour:
- Reset: state=FREE, cnt=0, working regs=0, result_o=0, ready_o=0. Reset mid-operation aborts immediately and the next edge starts from FREE.
- Outputs registered. Working dividend register is 2*WIDTH+1 bits.
- States:
  - FREE:
    - start_i=1, annul_i=0, divisor=0 -> DIVZERO.
    - start_i=1, annul_i=0, divisor!=0 -> ON: cnt=0.
      - Signed mode: negative operands are replaced by their two's complement magnitudes.
      - Working reg = {0^WIDTH, |op1|, 1'b0}; divisor magnitude latched.
    - Otherwise stay; ready_o=0, result_o=0.
  - DIVZERO: working reg cleared -> END (result 0).
  - ON:
    - annul_i=1 -> FREE, ready_o stays 0.
    - Else if cnt!=WIDTH:
      - diff = {0, work[2W-1:W]} - {0, divisor} (WIDTH+1 bits).
      - diff negative -> work = {work[2W-1:0], 0}.
      - Otherwise work = {diff[W-1:0], work[W-1:0], 1}.
      - cnt++.
    - Else (cnt==WIDTH): sign correction, then -> END, cnt=0.
      - Signed and op1 sign != op2 sign -> quotient (work[W-1:0]) negated.
      - Signed and op1 negative -> remainder (work[2W:W+1]) negated. Remainder takes the dividend's sign.
      - Signs are from the operands latched at start.
  - END:
    - result_o = {work[2W:W+1], work[W-1:0]}, ready_o=1.
    - start_i=0 -> FREE with ready_o=0 and result_o=0 on that edge.
    - start_i=1 -> remain in END, holding the result.
- Latency (E0 = edge sampling start in FREE):
  - Iterations occur at E1..E32; sign fix/END at E33; ready_o=1 after E34.
  - Divide-by-zero: ready_o=1 after E2.
- Operand inputs are ignored after E0. They are latched, so EX may change them.
- start_i dropping during ON does not abort; only annul_i or rst abort.
- annul_i is ignored in FREE (no start accepted), DIVZERO and END.
- Overflow: signed 0x80000000 / -1 -> quotient 0x80000000, remainder 0 (wraps, no trap).
- New request is accepted no earlier than the edge after END->FREE.

Decomposition:
- Shared defines (defines.v):
  - state encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady/NotReady.
  - DivStart/DivStop.
  - Reuse ZeroWord and DoubleRegBus.
- Single module, no sub-module. The per-iteration subtract/shift stays inline.

Test Plan:
- Unsigned 100/7 (signed_div_i=0), start held -> ready_o rises after E34; result_o = {32'h2, 32'hE}; holds until start_i low, then ready_o=0, result_o=0.
- Signed -7/2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 7/-2 -> {32'h1, 32'hFFFFFFFD}.
- Divisor 0 (any dividend) -> ready_o after E2, result_o = 0.
- annul_i pulsed at 10th iteration -> ready_o never asserts, state FREE; next start of 9/3 completes with {0, 3}.
- Signed 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}. Unsigned 0xFFFFFFFF/1 -> {0, 32'hFFFFFFFF}.
- rst asserted mid-division (cnt=20) -> next cycle ready_o=0, result_o=0; fresh 50/5 after release -> {0, 32'hA} at nominal latency.
